// File: rtl/stump_control_fsm_pkg.sv
// Shared Stump definitions: controller state codes, opcodes and the
// branch-condition evaluation used by both the controller and the datapath.
package stump_control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'b000,
    ST_EXECUTE = 3'b001,
    ST_MEMORY  = 3'b010,
    ST_HALT    = 3'b100,
    ST_ERROR   = 3'b101
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;

  localparam logic [2:0] REG_PC  = 3'd7;

  // cc is {N,Z,V,C}. Conditions come in pairs: odd codes are the inverse of
  // the even code below them, so evaluate the even form and flip with cond[0].
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] cc);
    logic n, z, v, c, r;
    n = cc[3];
    z = cc[2];
    v = cc[1];
    c = cc[0];
    case (cond[3:1])
      3'd0:    r = 1'b1;
      3'd1:    r = ~(c | z);
      3'd2:    r = ~c;
      3'd3:    r = ~z;
      3'd4:    r = ~v;
      3'd5:    r = ~n;
      3'd6:    r = ~(n ^ v);
      default: r = ~((n ^ v) | z);
    endcase
    return r ^ cond[0];
  endfunction

endpackage

// File: rtl/stump_branch_cond.sv
// Combinational branch-condition evaluator wrapping the shared function.
module stump_branch_cond
  import stump_control_fsm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);

  // Condition truth from the flag register.
  assign taken = cond_eval(cond, cc);

endmodule

// File: rtl/stump_control_fsm.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer with instruction decode,
// memory wait handshake and bus timeout, debug halt/single-step and a
// retired-instruction counter.
//
// Memory handshake: while mem_ren or mem_wen is high in FETCH/MEMORY, the
// access completes in the cycle where mem_ready is sampled high; the strobe
// and all decoded controls are held unchanged until then.
module stump_control_fsm
  import stump_control_fsm_pkg::*;
#(
  parameter int MEM_HANDSHAKE  = 1,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic [3:0]       cc,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             step,
  output logic [2:0]       state,
  output logic             fetch,
  output logic             execute,
  output logic             memory,
  output logic             halted,
  output logic             ir_en,
  output logic             reg_write,
  output logic [2:0]       dest,
  output logic [2:0]       srcA,
  output logic [2:0]       srcB,
  output logic [1:0]       shift_op,
  output logic             opB_mux_sel,
  output logic             ext_op,
  output logic [2:0]       alu_func,
  output logic             cc_en,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic             branch_taken,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  // The counter only ever holds values below TIMEOUT_CYCLES: the cycle that
  // would reach it moves the FSM to ERROR, which clears the count.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                done;
  logic                wait_last;
  logic                retire;
  logic                timeout_hit;
  logic                cond_true;
  logic [2:0]          opcode;

  assign opcode    = ir[15:13];
  assign done      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign wait_last = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

  stump_branch_cond u_branch_cond (
    .cond  (ir[11:8]),
    .cc    (cc),
    .taken (cond_true)
  );

  assign state   = state_q;
  assign fetch   = (state_q == ST_FETCH);
  assign execute = (state_q == ST_EXECUTE);
  assign memory  = (state_q == ST_MEMORY);
  assign halted  = (state_q == ST_HALT);

  // Next-state logic and instruction decode; every control defaults to 0.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    timeout_hit  = 1'b0;
    ir_en        = 1'b0;
    reg_write    = 1'b0;
    dest         = 3'd0;
    srcA         = 3'd0;
    srcB         = 3'd0;
    shift_op     = 2'd0;
    opB_mux_sel  = 1'b0;
    ext_op       = 1'b0;
    alu_func     = 3'd0;
    cc_en        = 1'b0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    branch_taken = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_ren = 1'b1;
        srcA    = REG_PC;
        if (done) begin
          ir_en     = 1'b1;
          reg_write = 1'b1;
          dest      = REG_PC;
          state_d   = ST_EXECUTE;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_d     = ST_ERROR;
        end
      end
      ST_EXECUTE: begin
        if (opcode == OP_BCC) begin
          srcA         = REG_PC;
          dest         = REG_PC;
          ext_op       = 1'b1;
          opB_mux_sel  = 1'b1;
          alu_func     = OP_BCC;
          branch_taken = cond_true;
          reg_write    = cond_true;
          retire       = 1'b1;
        end else if (opcode == OP_LDST) begin
          srcA        = ir[7:5];
          srcB        = ir[4:2];
          opB_mux_sel = ir[12];
          alu_func    = OP_LDST;
          state_d     = ST_MEMORY;
        end else begin
          reg_write   = 1'b1;
          dest        = ir[10:8];
          srcA        = ir[7:5];
          alu_func    = opcode;
          cc_en       = ir[11];
          opB_mux_sel = ir[12];
          if (!ir[12]) begin
            srcB     = ir[4:2];
            shift_op = ir[1:0];
          end
          retire = 1'b1;
        end
      end
      ST_MEMORY: begin
        mem_wen = ir[11];
        mem_ren = ~ir[11];
        if (ir[11]) begin
          srcA = ir[10:8];
        end else begin
          dest      = ir[10:8];
          reg_write = done;
        end
        if (done) begin
          retire = 1'b1;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_d     = ST_ERROR;
        end
      end
      ST_HALT: begin
        if (!halt_req || step) state_d = ST_FETCH;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (retire) state_d = halt_req ? ST_HALT : ST_FETCH;
  end

  // State register, wait counter, retire counter and sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
      bus_error   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d == state_q) && !done &&
          ((state_q == ST_FETCH) || (state_q == ST_MEMORY)))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
      if (retire)      instr_count <= instr_count + CNT_W'(1);
      if (timeout_hit) bus_error   <= 1'b1;
    end
  end

endmodule
